// File: rtl/qspline_pkg.sv
// Shared definitions for the quadratic spline evaluator.
// Holds coefficient-select encodings, parameter defaults and the
// fixed-point multiply/shift helper used by both Horner steps.
package qspline_pkg;

  // coef_sel encoding
  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // Parameter defaults
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FRAC_W     = 16;
  localparam int DEF_SEG_BITS   = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  // Widest DATA_W the helper below supports. Callers sign-extend the
  // coefficient and zero-extend t to this width, then truncate the
  // result back to DATA_W, which yields exactly the low DATA_W bits of
  // (coef * t) >>> frac_w as computed at 2*DATA_W bits.
  localparam int MAX_W = 64;

  // Signed coefficient times unsigned t, arithmetic (floor) shift right.
  function automatic logic signed [2*MAX_W-1:0] mul_shift(
    input logic signed [MAX_W-1:0] coef,
    input logic        [MAX_W-1:0] t,
    input int unsigned             frac_w
  );
    logic signed [2*MAX_W-1:0] p;
    p = $signed({{MAX_W{coef[MAX_W-1]}}, coef}) * $signed({{MAX_W{1'b0}}, t});
    return p >>> frac_w;
  endfunction

endpackage

// File: rtl/qspline_ret_fifo.sv
// Return buffer holding finished spline results until the caller pops them.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: none internally; the caller limits occupancy to FIFO_DEPTH.
// Ports: clock/resetn; push + push_dat (write); pop (consume head);
//        empty (no valid head); head (oldest entry).
module qspline_ret_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full buffer is only safe when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: the head is only consumed while not empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/qspline_pipe.sv
// Piecewise quadratic evaluator: y = a + t*(b + t*c) per segment, in order.
// Latency: call accepted in cycle N returns done in cycle N+3 (empty buffer).
// Backpressure: busy rises once FIFO_DEPTH calls are in flight; stall holds the head.
// Ports: clock/resetn; start/busy/idx (call); done/stall/returndata (return);
//        coef_we/coef_addr/coef_sel/coef_data (coefficient register write).
module qspline_pipe
  import qspline_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int SEG_BITS   = DEF_SEG_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic                busy,
  input  logic [DATA_W-1:0]   idx,
  output logic                done,
  input  logic                stall,
  output logic [DATA_W-1:0]   returndata,
  input  logic                coef_we,
  input  logic [SEG_BITS-1:0] coef_addr,
  input  logic [1:0]          coef_sel,
  input  logic [DATA_W-1:0]   coef_data
);

  localparam int NSEG = 1 << SEG_BITS;
  localparam int TOP  = FRAC_W + SEG_BITS;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  // Coefficient register file
  logic [DATA_W-1:0] coef_a [NSEG];
  logic [DATA_W-1:0] coef_b [NSEG];
  logic [DATA_W-1:0] coef_c [NSEG];

  // Decode
  logic                ovf;
  logic [SEG_BITS-1:0] dec_seg;
  logic [FRAC_W-1:0]   dec_t;

  generate
    if (TOP < DATA_W) begin : g_ovf
      assign ovf = |idx[DATA_W-1:TOP];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

  // Out-of-range inputs pin to the far end of the last segment.
  assign dec_seg = ovf ? '1 : idx[TOP-1:FRAC_W];
  assign dec_t   = ovf ? '1 : idx[FRAC_W-1:0];

  // Flow control
  logic          accept;
  logic          pop;
  logic          fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [CW-1:0] inflight;

  // inflight covers every stage plus buffered results, so reserving a
  // slot at accept time guarantees the buffer can never overflow.
  assign busy       = (inflight == CW'(FIFO_DEPTH));
  assign accept     = start & ~busy;
  assign done       = ~fifo_empty;
  assign pop        = done & ~stall;
  assign returndata = done ? fifo_head : '0;

  // Pipeline registers: s1 holds the latched call, s2 holds the inner Horner term.
  logic              s1_vld;
  logic [FRAC_W-1:0] s1_t;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [DATA_W-1:0] s1_c;
  logic              s2_vld;
  logic [FRAC_W-1:0] s2_t;
  logic [DATA_W-1:0] s2_a;
  logic [DATA_W-1:0] s2_h;
  logic [DATA_W-1:0] h_nxt;
  logic [DATA_W-1:0] y_nxt;

  assign h_nxt = s1_b + DATA_W'(mul_shift(MAX_W'($signed(s1_c)), MAX_W'(s1_t), FRAC_W));
  assign y_nxt = s2_a + DATA_W'(mul_shift(MAX_W'($signed(s2_h)), MAX_W'(s2_t), FRAC_W));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_vld   <= 1'b0;
      s1_t     <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s2_vld   <= 1'b0;
      s2_t     <= '0;
      s2_a     <= '0;
      s2_h     <= '0;
      inflight <= '0;
    end else begin
      // Coefficients are captured here, so later writes never reach this call.
      s1_vld <= accept;
      if (accept) begin
        s1_t <= dec_t;
        s1_a <= coef_a[dec_seg];
        s1_b <= coef_b[dec_seg];
        s1_c <= coef_c[dec_seg];
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_t <= s1_t;
        s2_a <= s1_a;
        s2_h <= h_nxt;
      end
      if (accept && !pop)      inflight <= inflight + 1'b1;
      else if (pop && !accept) inflight <= inflight - 1'b1;
    end
  end

  // A call reading a segment in the same cycle it is written sees the old value.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NSEG; i++) begin
        coef_a[i] <= '0;
        coef_b[i] <= '0;
        coef_c[i] <= '0;
      end
    end else if (coef_we) begin
      case (coef_sel)
        SEL_A:   coef_a[coef_addr] <= coef_data;
        SEL_B:   coef_b[coef_addr] <= coef_data;
        SEL_C:   coef_c[coef_addr] <= coef_data;
        default: ;
      endcase
    end
  end

  qspline_ret_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ret_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (s2_vld),
    .push_dat (y_nxt),
    .pop      (pop),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_qspline_pipe.sv
module tb_qspline_pipe;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        busy;
  logic [31:0] idx;
  logic        done;
  logic        stall;
  logic [31:0] returndata;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [1:0]  coef_sel;
  logic [31:0] coef_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  qspline_pipe #(
    .DATA_W     (32),
    .FRAC_W     (16),
    .SEG_BITS   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .busy       (busy),
    .idx        (idx),
    .done       (done),
    .stall      (stall),
    .returndata (returndata),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_sel   (coef_sel),
    .coef_data  (coef_data)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] s, input logic [31:0] d);
    coef_we = 1'b1; coef_addr = a; coef_sel = s; coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic call(input logic [31:0] i);
    start = 1'b1; idx = i;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (returndata !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", returndata); end
  endtask

  task automatic test_basic();
    wr(4'd2, 2'd0, 32'h0001_0000);
    wr(4'd2, 2'd1, 32'h0002_0000);
    wr(4'd2, 2'd2, 32'h0001_0000);
    call(32'h0002_8000);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_n1 done=%b exp=0", done); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_n2 done=%b exp=0", done); end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_n3 done=%b exp=1", done); end
    total++; if (returndata !== 32'h0002_4000) begin bad++; $display("FAIL basic_data got=%h exp=00024000", returndata); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_popped done=%b exp=0", done); end
  endtask

  task automatic test_negative();
    bit ok;
    wr(4'd0, 2'd2, 32'hFFFF_0000);
    call(32'h0000_8000);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL neg_timeout done=%b exp=1", done); end
    total++; if (returndata !== 32'hFFFF_C000) begin bad++; $display("FAIL neg_data got=%h exp=ffffc000", returndata); end
    tick();
  endtask

  task automatic test_clamp();
    bit ok;
    wr(4'd15, 2'd1, 32'h0001_0000);
    wr(4'd15, 2'd3, 32'h1234_5678);   // select 3 must not touch any register
    call(32'h0010_0000);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL clamp_timeout done=%b exp=1", done); end
    total++; if (returndata !== 32'h0000_FFFF) begin bad++; $display("FAIL clamp_data got=%h exp=0000ffff", returndata); end
    tick();
    call(32'h8000_0000);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL clamp_msb_timeout done=%b exp=1", done); end
    total++; if (returndata !== 32'h0000_FFFF) begin bad++; $display("FAIL clamp_msb_data got=%h exp=0000ffff", returndata); end
    tick();
  endtask

  // Segment 3 is set to y = t, so each result equals the low 16 bits of idx.
  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic [31:0] e;
    logic        exp_done;
    wr(4'd3, 2'd1, 32'h0001_0000);
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        start = 1'b1;
        e = 32'((c + 1) << 12);
        idx = 32'h0003_0000 | e;
        exp_q.push_back(e);
      end else begin
        start = 1'b0;
      end
      exp_done = (c >= 3 && c <= 8);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy c=%0d got=%b exp=0", c, busy); end
      total++; if (done !== exp_done) begin bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, exp_done); end
      if (done === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if (returndata !== e) begin bad++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, returndata, e); end
      end
      tick();
    end
    start = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic exp_busy;
    stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      start = 1'b1;
      idx = 32'h0003_0000 | 32'((k + 1) << 12);
      exp_busy = (k >= 4);
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL bp_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
      tick();
    end
    start = 1'b0;
    tick(); tick(); tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy_held got=%b exp=1", busy); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done_held got=%b exp=1", done); end
    stall = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy_popcycle got=%b exp=1", busy); end
    total++; if (returndata !== 32'h0000_1000) begin bad++; $display("FAIL bp_r0 got=%h exp=00001000", returndata); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy_after got=%b exp=0", busy); end
    total++; if (returndata !== 32'h0000_2000) begin bad++; $display("FAIL bp_r1 got=%h exp=00002000", returndata); end
    tick();
    total++; if (returndata !== 32'h0000_3000) begin bad++; $display("FAIL bp_r2 got=%h exp=00003000", returndata); end
    tick();
    total++; if (returndata !== 32'h0000_4000) begin bad++; $display("FAIL bp_r3 got=%h exp=00004000", returndata); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL bp_extra done=%b exp=0", done); end
  endtask

  task automatic test_collision();
    bit ok;
    wr(4'd1, 2'd0, 32'h0001_0000);
    coef_we = 1'b1; coef_addr = 4'd1; coef_sel = 2'd0; coef_data = 32'h0005_0000;
    start = 1'b1; idx = 32'h0001_0000;
    tick();
    coef_we = 1'b0;
    tick();
    start = 1'b0;
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL coll_timeout done=%b exp=1", done); end
    total++; if (returndata !== 32'h0001_0000) begin bad++; $display("FAIL coll_old got=%h exp=00010000", returndata); end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL coll_second_done got=%b exp=1", done); end
    total++; if (returndata !== 32'h0005_0000) begin bad++; $display("FAIL coll_new got=%h exp=00050000", returndata); end
    tick();
  endtask

  task automatic test_midreset();
    bit ok;
    bit stale;
    start = 1'b1; idx = 32'h0002_8000;
    tick(); tick(); tick();
    start = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mr_done got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%b exp=0", busy); end
    total++; if (returndata !== 32'h0) begin bad++; $display("FAIL mr_data got=%h exp=0", returndata); end
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done !== 1'b0) stale = 1'b1;
      tick();
    end
    total++; if (stale) begin bad++; $display("FAIL mr_stale got=1 exp=0"); end
    call(32'h0002_8000);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL mr_seg2_timeout done=%b exp=1", done); end
    total++; if (returndata !== 32'h0) begin bad++; $display("FAIL mr_seg2_coef got=%h exp=0", returndata); end
    tick();
    call(32'h0000_8000);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL mr_seg0_timeout done=%b exp=1", done); end
    total++; if (returndata !== 32'h0) begin bad++; $display("FAIL mr_seg0_coef got=%h exp=0", returndata); end
    tick();
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; stall = 1'b0; idx = '0;
    coef_we = 1'b0; coef_addr = '0; coef_sel = '0; coef_data = '0;
    test_reset();
    test_basic();
    test_negative();
    test_clamp();
    test_back_to_back();
    test_backpressure();
    test_collision();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
